// File: rtl/fft_r22sdf_ctrl_if.sv
// Control bus between the radix-2^2 SDF FFT sequencer and the datapath it steers.
// The slave side is the sequencer; the master side is the datapath / sample source.
interface fft_r22sdf_ctrl_if #(
    parameter int N_LOG2 = 10
);
    localparam int N_STG = N_LOG2 / 2;
    localparam int TW_W  = (N_STG - 1) * N_LOG2;

    logic                valid_i;
    logic                frame_slot_o;
    logic [N_LOG2-1:0]   bf_sel_o;
    logic [N_STG-1:0]    bf_tsel_o;
    logic [TW_W-1:0]     tw_addr_o;
    logic                valid_o;
    logic                sof_o;
    logic [N_LOG2-1:0]   bin_o;
    logic                align_err_o;

    modport master (
        output valid_i,
        input  frame_slot_o,
        input  bf_sel_o,
        input  bf_tsel_o,
        input  tw_addr_o,
        input  valid_o,
        input  sof_o,
        input  bin_o,
        input  align_err_o
    );

    modport slave (
        input  valid_i,
        output frame_slot_o,
        output bf_sel_o,
        output bf_tsel_o,
        output tw_addr_o,
        output valid_o,
        output sof_o,
        output bin_o,
        output align_err_o
    );
endinterface

// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for a radix-2^2 SDF FFT: free-running timebase, butterfly/twiddle controls,
// frame gating, output validity/bin tracking and framing-error detection.
//
// state    | meaning
// ST_IDLE  | no frame open; a frame may only start when cnt == 0
// ST_FRAME | samples of an open frame are being accepted
module fft_r22sdf_ctrl #(
    parameter int N_LOG2   = 10,
    parameter int MULT_LAT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fft_r22sdf_ctrl_if.slave  bus
);
    localparam int N     = 1 << N_LOG2;
    localparam int N_STG = N_LOG2 / 2;
    localparam int N_TW  = N_STG - 1;
    localparam int TW_W  = N_TW * N_LOG2;
    localparam int LAT   = N - 1 + MULT_LAT * N_TW;

    typedef logic [N_LOG2-1:0] cnt_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Local count of butterfly k: the timebase as seen by data arriving at that butterfly.
    function automatic cnt_t local_cnt(input cnt_t cnt, input int k);
        int dly;
        dly = (N - (N >> k)) + MULT_LAT * (k / 2);
        return cnt - cnt_t'(dly);
    endfunction

    function automatic logic [N_LOG2-1:0] sel_of(input cnt_t cnt);
        logic [N_LOG2-1:0] sel;
        cnt_t              c;
        sel = '0;
        for (int k = 0; k < N_LOG2; k++) begin
            c      = local_cnt(cnt, k);
            sel[k] = c[N_LOG2-1-k];
        end
        return sel;
    endfunction

    // tsel follows the select bit of the paired BF I, but timed for the BF II position.
    function automatic logic [N_STG-1:0] tsel_of(input cnt_t cnt);
        logic [N_STG-1:0] tsel;
        cnt_t             c;
        tsel = '0;
        for (int s = 0; s < N_STG; s++) begin
            c       = local_cnt(cnt, 2 * s + 1);
            tsel[s] = c[N_LOG2-1-2*s];
        end
        return tsel;
    endfunction

    function automatic logic [TW_W-1:0] tw_of(input cnt_t cnt);
        logic [TW_W-1:0] tw;
        cnt_t            cm;
        cnt_t            n3;
        cnt_t            mask;
        cnt_t            prod;
        logic [1:0]      kk;
        tw = '0;
        for (int s = 0; s < N_TW; s++) begin
            cm   = local_cnt(cnt, 2 * s + 2) - cnt_t'(MULT_LAT);
            mask = cnt_t'((1 << (N_LOG2 - 2 * s - 2)) - 1);
            n3   = cm & mask;
            // {k2, k1} is k1 + 2*k2 as a 2-bit number
            kk   = {cm[N_LOG2-2*s-2], cm[N_LOG2-2*s-1]};
            prod = n3 * cnt_t'(kk);
            tw[s*N_LOG2 +: N_LOG2] = prod << (2 * s);
        end
        return tw;
    endfunction

    cnt_t              cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic              valid_prev_q;
    logic [LAT-1:0]    dly_q, dly_d;
    logic [N_LOG2-1:0] sel_q, sel_d;
    logic [N_STG-1:0]  tsel_q, tsel_d;
    logic [TW_W-1:0]   tw_q, tw_d;

    logic              at_zero;
    logic              at_last;
    logic              acc;
    logic              err;
    logic              valid_out;
    cnt_t              out_pos;
    logic [N_LOG2-1:0] bin_rev;

    assign at_zero = (cnt_q == '0);
    assign at_last = (cnt_q == cnt_t'(N - 1));
    assign cnt_d   = cnt_q + 1'b1;

    // Controls are computed one cycle early so the registered value matches the live cnt.
    assign sel_d  = sel_of(cnt_d);
    assign tsel_d = tsel_of(cnt_d);
    assign tw_d   = tw_of(cnt_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            valid_prev_q <= 1'b0;
            dly_q        <= '0;
            sel_q        <= sel_of(cnt_t'(0));
            tsel_q       <= tsel_of(cnt_t'(0));
            tw_q         <= tw_of(cnt_t'(0));
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            valid_prev_q <= bus.valid_i;
            dly_q        <= dly_d;
            sel_q        <= sel_d;
            tsel_q       <= tsel_d;
            tw_q         <= tw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    if (at_zero) begin
                        acc     = 1'b1;
                        state_d = ST_FRAME;
                    end else if (!valid_prev_q) begin
                        err = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (!bus.valid_i) begin
                    state_d = ST_IDLE;
                    err     = !at_zero;
                end else begin
                    acc = 1'b1;
                    // a continuing valid re-opens the next frame from ST_IDLE at cnt == 0
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dly_d     = {dly_q[LAT-2:0], acc};
    assign valid_out = dly_q[LAT-1];
    assign out_pos   = cnt_q - cnt_t'(LAT);

    always_comb begin
        bin_rev = '0;
        for (int b = 0; b < N_LOG2; b++) begin
            bin_rev[b] = out_pos[N_LOG2-1-b];
        end
    end

    assign bus.frame_slot_o = at_zero;
    assign bus.bf_sel_o     = sel_q;
    assign bus.bf_tsel_o    = tsel_q;
    assign bus.tw_addr_o    = tw_q;
    assign bus.valid_o      = valid_out;
    assign bus.sof_o        = valid_out && (out_pos == '0);
    assign bus.bin_o        = valid_out ? bin_rev : '0;
    assign bus.align_err_o  = err;
endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Directed bench for fft_r22sdf_ctrl: N=16 with MULT_LAT 0 (d0) and 2 (d2), output scoreboard.
module tb_fft_r22sdf_ctrl;
    localparam int NL    = 4;
    localparam int N     = 16;
    localparam int NT    = NL / 2;
    localparam int TWW   = (NT - 1) * NL;
    localparam int LAT_A = 15;
    localparam int LAT_B = 17;

    typedef struct {
        int cyc;
        int bin;
        bit sof;
    } exp_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst2 = 1'b1;
    int   cyc  = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   base[2];
    bit   en[2];
    bit   exp_err[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_r22sdf_ctrl_if #(.N_LOG2(NL)) if0 ();
    fft_r22sdf_ctrl_if #(.N_LOG2(NL)) if2 ();

    fft_r22sdf_ctrl #(.N_LOG2(NL), .MULT_LAT(0)) dut0 (.clk_i(clk), .rst_i(rst0), .bus(if0.slave));
    fft_r22sdf_ctrl #(.N_LOG2(NL), .MULT_LAT(2)) dut2 (.clk_i(clk), .rst_i(rst2), .bus(if2.slave));

    function automatic int mod_n(input int x, input int n);
        return ((x % n) + n) % n;
    endfunction

    function automatic int bitrev(input int p);
        int r;
        r = 0;
        for (int b = 0; b < NL; b++) if (((p >> b) & 1) != 0) r |= 1 << (NL - 1 - b);
        return r;
    endfunction

    function automatic int lcnt(input int cnt, input int k, input int ml);
        return mod_n(cnt - ((N - (N >> k)) + ml * (k / 2)), N);
    endfunction

    function automatic int exp_sel(input int cnt, input int ml);
        int r;
        r = 0;
        for (int k = 0; k < NL; k++) if (((lcnt(cnt, k, ml) / (N >> (k + 1))) % 2) != 0) r |= 1 << k;
        return r;
    endfunction

    function automatic int exp_tsel(input int cnt, input int ml);
        int r;
        r = 0;
        for (int s = 0; s < NT; s++)
            if (((lcnt(cnt, 2 * s + 1, ml) / (N >> (2 * s + 1))) % 2) != 0) r |= 1 << s;
        return r;
    endfunction

    function automatic int exp_tw(input int cnt, input int ml);
        int r, cm, m, k1, k2, n3;
        r = 0;
        for (int s = 0; s < NT - 1; s++) begin
            cm = mod_n(lcnt(cnt, 2 * s + 2, ml) - ml, N);
            m  = N / (1 << (2 * s));
            k1 = (cm / (m / 2)) % 2;
            k2 = (cm / (m / 4)) % 2;
            n3 = cm % (m / 4);
            r |= (((1 << (2 * s)) * n3 * (k1 + 2 * k2)) % N) << (s * NL);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic mon(input int d, input string p, input logic slot, input logic [NL-1:0] sel,
                       input logic [NT-1:0] tsel, input logic [TWW-1:0] tw, input logic vo,
                       input logic sof, input logic [NL-1:0] bin, input logic err);
        int   c, ml;
        bit   have;
        exp_t e;
        ml = (d == 0) ? 0 : 2;
        c  = mod_n(cyc - base[d], N);
        chk({p, "_slot"}, 32'(slot), 32'(c == 0));
        chk({p, "_sel"},  32'(sel),  32'(exp_sel(c, ml)));
        chk({p, "_tsel"}, 32'(tsel), 32'(exp_tsel(c, ml)));
        chk({p, "_tw"},   32'(tw),   32'(exp_tw(c, ml)));
        chk({p, "_err"},  32'(err),  32'(exp_err[d]));
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        if (have && e.cyc == cyc) chk({p, "_valid_due"}, 32'(vo), 32'(1));
        if (vo) begin
            chk({p, "_valid_expected"}, 32'(have), 32'(1));
            if (have) begin
                chk({p, "_out_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({p, "_bin"}, 32'(bin), 32'(e.bin));
                chk({p, "_sof"}, 32'(sof), 32'(e.sof));
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end else begin
            chk({p, "_sof_idle"}, 32'(sof), 32'(0));
            chk({p, "_bin_idle"}, 32'(bin), 32'(0));
        end
    endtask

    always @(negedge clk) begin
        if (en[0]) mon(0, "d0", if0.frame_slot_o, if0.bf_sel_o, if0.bf_tsel_o, if0.tw_addr_o,
                       if0.valid_o, if0.sof_o, if0.bin_o, if0.align_err_o);
        if (en[1]) mon(1, "d2", if2.frame_slot_o, if2.bf_sel_o, if2.bf_tsel_o, if2.tw_addr_o,
                       if2.valid_o, if2.sof_o, if2.bin_o, if2.align_err_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one cycle; accepted samples push their expected output onto the scoreboard
    task automatic drv(input int d, input bit v, input bit acc, input int pos, input bit err);
        exp_t e;
        if (d == 0) if0.valid_i = v; else if2.valid_i = v;
        exp_err[d] = err;
        if (acc) begin
            e.cyc = cyc + ((d == 0) ? LAT_A : LAT_B);
            e.bin = bitrev(pos);
            e.sof = (pos == 0);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        step();
    endtask

    task automatic do_reset(input int d, input bit v);
        en[d]      = 1'b0;
        exp_err[d] = 1'b0;
        if (d == 0) begin rst0 = 1'b1; if0.valid_i = v; end
        else begin rst2 = 1'b1; if2.valid_i = v; end
        step();
        if (d == 0) rst0 = 1'b0; else rst2 = 1'b0;
        base[d] = cyc;
        en[d]   = 1'b1;
    endtask

    task automatic align_to(input int d, input int target);
        for (int i = 0; i < N && mod_n(cyc - base[d], N) != target; i++) drv(d, 0, 0, 0, 0);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) drv(d, 0, 0, 0, 0);
    endtask

    initial begin
        if0.valid_i = 1'b0;
        if2.valid_i = 1'b0;
        en[0] = 1'b0; en[1] = 1'b0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        base[0] = 0; base[1] = 0;
        step();

        do_reset(0, 1'b0);
        chk("rst_slot",  32'(if0.frame_slot_o), 32'(1));
        chk("rst_valid", 32'(if0.valid_o), 32'(0));
        chk("rst_sof",   32'(if0.sof_o), 32'(0));
        chk("rst_bin",   32'(if0.bin_o), 32'(0));
        chk("rst_sel",   32'(if0.bf_sel_o), 32'(0));
        chk("rst_tsel",  32'(if0.bf_tsel_o), 32'(3));
        chk("rst_tw",    32'(if0.tw_addr_o), 32'(0));

        for (int i = 0; i < N; i++) begin
            chk("sel0_table", 32'(if0.bf_sel_o[0]), 32'(i >= 8));
            chk("sel1_table", 32'(if0.bf_sel_o[1]), 32'((i >= 12) || (i >= 4 && i <= 7)));
            if (i == 3) chk("tw_cnt3", 32'(if0.tw_addr_o), 32'(6));
            drv(0, 1, 1, i, 0);
        end
        idle(0, 40);

        align_to(0, 0);
        for (int i = 0; i < 2 * N; i++) drv(0, 1, 1, i % N, 0);
        idle(0, 40);

        align_to(0, 5);
        drv(0, 1, 0, 0, 1);
        drv(0, 1, 0, 0, 0);
        drv(0, 1, 0, 0, 0);
        idle(0, 40);

        align_to(0, 0);
        for (int i = 0; i < 9; i++) drv(0, 1, 1, i, 0);
        drv(0, 0, 0, 0, 1);
        idle(0, 40);

        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++) drv(1, 1, 0, i, 0);
        do_reset(1, 1'b1);
        chk("mid_rst_slot",  32'(if2.frame_slot_o), 32'(1));
        chk("mid_rst_valid", 32'(if2.valid_o), 32'(0));
        chk("mid_rst_sof",   32'(if2.sof_o), 32'(0));
        chk("mid_rst_err",   32'(if2.align_err_o), 32'(0));
        chk("mid_rst_sel",   32'(if2.bf_sel_o), 32'(exp_sel(0, 2)));
        chk("mid_rst_tsel",  32'(if2.bf_tsel_o), 32'(exp_tsel(0, 2)));
        chk("mid_rst_tw",    32'(if2.tw_addr_o), 32'(exp_tw(0, 2)));
        for (int i = 0; i < N; i++) drv(1, 1, 1, i, 0);
        idle(1, 40);

        chk("d0_queue_drained", 32'(q0.size()), 32'(0));
        chk("d2_queue_drained", 32'(q1.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
